// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes and FSM states.
package alu_pkg;

    // Operation codes driven by the ALU controller
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_MUL = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SLE = 4'd9;
    localparam logic [3:0] ALU_NOR = 4'd12;

    // IDLE accepts requests; MUL blocks the pipeline while the multiplier iterates
    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles total.
// product_o is combinational so the caller can capture the final sum on the done edge.
module alu_seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] accSum;

    assign accSum    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product_o = accSum;
    assign done_o    = busy_q && (cnt_q == LAST);

    // Next-state: load on start, otherwise add-then-shift one step per cycle while busy
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (flush_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = accSum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    // Datapath registers, cleared asynchronously so a reset discards any product in progress
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/shift/add/compare, multi-cycle multiply,
// registered Result/Zero/Overflow with a one-cycle Out_Valid strobe.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Out_Valid,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    alu_state_e       state_q, state_d;
    logic             accept, mulStart, singleValid;
    logic             mulDone;
    logic [WIDTH-1:0] mulProduct;
    logic [WIDTH-1:0] sum, diff, aluRes;
    logic             aluOv, sLess;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, overflow_q, outValid_q;

    // Flush wins over a request presented in the same cycle
    assign accept      = In_Valid && In_Ready && !Flush;
    assign mulStart    = accept && (ALUControl == ALU_MUL);
    assign singleValid = accept && (ALUControl != ALU_MUL);

    assign sum   = A + B;
    assign diff  = A - B;
    assign sLess = $signed(A) < $signed(B);
    assign shamt = B[SHW-1:0];

    alu_seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start_i   (mulStart),
        .flush_i   (Flush),
        .a_i       (A),
        .b_i       (B),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );

    // Single-cycle datapath; overflow follows the two's-complement sign rule
    always_comb begin
        aluRes = '0;
        aluOv  = 1'b0;
        case (ALUControl)
            ALU_AND: aluRes = A & B;
            ALU_OR:  aluRes = A | B;
            ALU_ADD: begin
                aluRes = sum;
                aluOv  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_XOR: aluRes = A ^ B;
            ALU_SLL: aluRes = A << shamt;
            ALU_SUB: begin
                aluRes = diff;
                aluOv  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_SLT: aluRes = WIDTH'(sLess);
            ALU_SRL: aluRes = A >> shamt;
            ALU_SLE: aluRes = WIDTH'(sLess || (A == B));
            ALU_NOR: aluRes = ~(A | B);
            default: aluRes = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enter MUL on an accepted multiply, leave on done or flush
    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (mulStart) state_d = MUL;
                MUL:     if (mulDone)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: ready only in IDLE and never while reset is asserted
    always_comb begin
        In_Ready = (state_q == IDLE) && Reset_n;
    end

    // Output registers: load on single-cycle accept or multiply completion, hold otherwise
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            if (!Flush) begin
                if (singleValid) begin
                    result_q   <= aluRes;
                    zero_q     <= (aluRes == '0);
                    overflow_q <= aluOv;
                    outValid_q <= 1'b1;
                end else if ((state_q == MUL) && mulDone) begin
                    result_q   <= mulProduct;
                    zero_q     <= (mulProduct == '0);
                    overflow_q <= 1'b0;
                    outValid_q <= 1'b1;
                end
            end
        end
    end

    assign Result    = result_q;
    assign Zero      = zero_q;
    assign Overflow  = overflow_q;
    assign Out_Valid = outValid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases followed by
// randomized operations compared against an arithmetic reference model.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic             Clk;
    logic             Reset_n;
    logic             In_Valid;
    logic             In_Ready;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Flush;
    logic             Out_Valid;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Overflow;

    int assertCount = 0;
    int failCount   = 0;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .Flush      (Flush),
        .Out_Valid  (Out_Valid),
        .Result     (Result),
        .Zero       (Zero),
        .Overflow   (Overflow)
    );

    // Free-running clock, 10 time units per cycle
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every evaluation and every failure
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: results from plain wide arithmetic on the operation meaning
    function automatic void refModel(input int code, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output logic ov);
        longint sa;
        longint sb;
        longint s;
        logic [63:0] p;
        int sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sh  = int'(b & 32'd31);
        res = 32'd0;
        ov  = 1'b0;
        case (code)
            0:  res = a & b;
            1:  res = a | b;
            2:  begin s = sa + sb; res = a + b; ov = (s > MAXS) || (s < MINS); end
            3:  begin p = {32'd0, a} * {32'd0, b}; res = p[31:0]; end
            4:  res = a ^ b;
            5:  res = a << sh;
            6:  begin s = sa - sb; res = a - b; ov = (s > MAXS) || (s < MINS); end
            7:  res = (sa < sb) ? 32'd1 : 32'd0;
            8:  res = a >> sh;
            9:  res = (sa <= sb) ? 32'd1 : 32'd0;
            12: res = ~(a | b);
            default: res = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        ALUControl = code;
        A          = a;
        B          = b;
        In_Valid   = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expRes, input logic expOv);
        check({tag, ".valid"}, 64'(Out_Valid), 64'd1);
        check({tag, ".result"}, 64'(Result), 64'(expRes));
        check({tag, ".zero"}, 64'(Zero), 64'(expRes == 32'd0));
        check({tag, ".ovf"}, 64'(Overflow), 64'(expOv));
    endtask

    // One isolated request, bounded wait for its result, latency and value checks
    task automatic runOp(input string tag, input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes, input logic expOv);
        int lat;
        int expLat;
        @(negedge Clk);
        check({tag, ".ready"}, 64'(In_Ready), 64'd1);
        applyStimulus(code, a, b);
        @(negedge Clk);
        In_Valid = 1'b0;
        lat = 1;
        while (Out_Valid !== 1'b1 && lat < WIDTH + 8) begin
            @(negedge Clk);
            lat++;
        end
        expLat = (code == ALU_MUL) ? WIDTH + 1 : 1;
        check({tag, ".latency"}, 64'(lat), 64'(expLat));
        checkOutput(tag, expRes, expOv);
    endtask

    initial begin
        logic [31:0] rA;
        logic [31:0] rB;
        logic [31:0] rRes;
        logic        rOv;
        logic [3:0]  rCode;

        Reset_n    = 1'b1;
        In_Valid   = 1'b0;
        Flush      = 1'b0;
        ALUControl = 4'd0;
        A          = '0;
        B          = '0;
        #1 Reset_n = 1'b0;
        #2;
        check("rst.ready", 64'(In_Ready), 64'd0);
        check("rst.valid", 64'(Out_Valid), 64'd0);
        check("rst.result", 64'(Result), 64'd0);
        check("rst.zero", 64'(Zero), 64'd1);
        check("rst.ovf", 64'(Overflow), 64'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        check("rst.ready_rel", 64'(In_Ready), 64'd1);

        $display("[TB] back-to-back single-cycle operations");
        @(negedge Clk);
        applyStimulus(ALU_ADD, 32'd5, 32'd7);
        @(negedge Clk);
        checkOutput("b2b_add", 32'd12, 1'b0);
        applyStimulus(ALU_SUB, 32'd3, 32'd3);
        @(negedge Clk);
        checkOutput("b2b_sub", 32'd0, 1'b0);
        applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        @(negedge Clk);
        checkOutput("b2b_slt", 32'd1, 1'b0);
        applyStimulus(ALU_SLE, 32'd4, 32'd4);
        @(negedge Clk);
        checkOutput("b2b_sle", 32'd1, 1'b0);
        In_Valid = 1'b0;
        @(negedge Clk);
        check("b2b_idle.valid", 64'(Out_Valid), 64'd0);
        check("b2b_idle.hold", 64'(Result), 64'd1);

        $display("[TB] signed overflow");
        runOp("ovf_add", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
        runOp("ovf_sub", ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1);

        $display("[TB] multiply timing");
        @(negedge Clk);
        check("mul.ready", 64'(In_Ready), 64'd1);
        applyStimulus(ALU_MUL, 32'd1234, 32'd5678);
        @(negedge Clk);
        In_Valid = 1'b0;
        for (int i = 1; i <= WIDTH; i++) begin
            check($sformatf("mul.busy_ready%0d", i), 64'(In_Ready), 64'd0);
            check($sformatf("mul.busy_valid%0d", i), 64'(Out_Valid), 64'd0);
            @(negedge Clk);
        end
        checkOutput("mul_1234x5678", 32'd7006652, 1'b0);
        check("mul.ready_done", 64'(In_Ready), 64'd1);
        applyStimulus(ALU_ADD, 32'd10, 32'd20);
        @(negedge Clk);
        In_Valid = 1'b0;
        checkOutput("mul_then_add", 32'd30, 1'b0);
        runOp("mul_ffxff", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);

        $display("[TB] shifts and miscellaneous codes");
        runOp("code13", 4'd13, 32'd5, 32'd3, 32'd0, 1'b0);
        runOp("sll", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0);
        runOp("srl", ALU_SRL, 32'h8000_0000, 32'd31, 32'd1, 1'b0);
        runOp("nor", ALU_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);

        $display("[TB] flush during multiply");
        @(negedge Clk);
        applyStimulus(ALU_MUL, 32'd1234, 32'd5678);
        @(negedge Clk);
        In_Valid = 1'b0;
        repeat (9) @(negedge Clk);
        Flush = 1'b1;
        applyStimulus(ALU_ADD, 32'd1, 32'd2);
        @(negedge Clk);
        Flush    = 1'b0;
        In_Valid = 1'b0;
        check("flush.valid", 64'(Out_Valid), 64'd0);
        check("flush.ready", 64'(In_Ready), 64'd1);
        check("flush.hold", 64'(Result), 64'hFFFF_FFFF);
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(negedge Clk);
            check($sformatf("flush.quiet%0d", i), 64'(Out_Valid), 64'd0);
        end
        check("flush.hold_end", 64'(Result), 64'hFFFF_FFFF);

        $display("[TB] reset during multiply");
        runOp("pre_rst_add", ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
        @(negedge Clk);
        applyStimulus(ALU_MUL, 32'd3, 32'd4);
        @(negedge Clk);
        In_Valid = 1'b0;
        repeat (5) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("midrst.ready", 64'(In_Ready), 64'd0);
        check("midrst.result", 64'(Result), 64'd0);
        check("midrst.zero", 64'(Zero), 64'd1);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < WIDTH + 8; i++) begin
            @(negedge Clk);
            check($sformatf("midrst.quiet%0d", i), 64'(Out_Valid), 64'd0);
        end
        check("midrst.ready_rel", 64'(In_Ready), 64'd1);
        check("midrst.result_end", 64'(Result), 64'd0);
        check("midrst.zero_end", 64'(Zero), 64'd1);

        $display("[TB] randomized operations");
        for (int i = 0; i < 150; i++) begin
            rCode = 4'($urandom_range(0, 15));
            rA    = pickOperand();
            rB    = pickOperand();
            refModel(int'(rCode), rA, rB, rRes, rOv);
            runOp($sformatf("rnd%0d_op%0d", i, rCode), rCode, rA, rB, rRes, rOv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
